msk_aes_share_loader: RTL and testbench

- Upstream feeder for MSKaes_32bits_core.
- Accepts pre-shared plaintext and 256-bit key material as a stream of 32-bit words and assembles the flat buses sh_plaintext (128*d bits) and sh_key (256*d bits).
- Presents the assembled buses, plus the inverse flag, to the core with a valid/ready handshake.
- Does not re-share or recombine anything: the incoming words are already the shares.

---
 rtl/msk_aes_share_loader_pkg.sv | 12 +
 rtl/msk_aes_share_loader_deserializer.sv | 22 ++
 rtl/msk_aes_share_loader.sv | 90 +++++++++
 tb/tb_msk_aes_share_loader.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/msk_aes_share_loader_pkg.sv
// msk_aes_share_loader_pkg: shared word-count helpers, state encoding and width defaults for the share loader.
package msk_aes_share_loader_pkg;
    localparam int D_DEF = 2;
    localparam int W_DEF = 32;
    typedef enum logic [1:0] {ST_LOAD_PT, ST_LOAD_KEY, ST_HOLD} state_t;
    function automatic int npt_words(input int d, input int w);
        return 128 * d / w;
    endfunction
    function automatic int nk_words(input int d, input int w);
        return 256 * d / w;
    endfunction
endpackage

// File: rtl/msk_aes_share_loader_deserializer.sv
// msk_word_deserializer: writes one W-bit word into slot i_idx of an N-word register bank.
module msk_word_deserializer
    import msk_aes_share_loader_pkg::*;
#(
    parameter int N  = 8,
    parameter int W  = W_DEF,
    parameter int IW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_en,
    input  logic [IW-1:0]   i_idx,
    input  logic [W-1:0]    i_word,
    output logic [N*W-1:0]  o_bank
);
    logic [N*W-1:0] r_bank;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_bank <= '0;
        else for (int k = 0; k < N; k++) if (i_en && i_idx == IW'(k)) r_bank[k*W +: W] <= i_word;
    end
    assign o_bank = r_bank;
endmodule

// File: rtl/msk_aes_share_loader.sv
// msk_aes_share_loader: assembles pre-shared plaintext/key word streams into flat buses for the masked AES core.
// Optional AES_KEY_REUSE_EN adds in_new_key so a block can reuse the previously loaded key.
module msk_aes_share_loader
    import msk_aes_share_loader_pkg::*;
#(
    parameter int d = D_DEF,
    parameter int W = W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_inverse,
`ifdef AES_KEY_REUSE_EN
    input  logic             in_new_key,
`endif
    output logic [128*d-1:0] sh_plaintext,
    output logic [256*d-1:0] sh_key,
    output logic             inverse,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);
    localparam int NPT = npt_words(d, W);
    localparam int NK  = nk_words(d, W);
    localparam int CW  = $clog2(NK);
    state_t r_state, w_next;
    logic [CW-1:0] r_cnt, w_cnt_next;
    logic r_up, r_inv, r_key_loaded;
    logic w_acc, w_pt_last, w_key_last, w_skip_key;
    assign in_ready   = r_up & (r_state != ST_HOLD);
    assign w_acc      = in_valid & in_ready;
    assign w_pt_last  = r_cnt == CW'(NPT - 1);
    assign w_key_last = r_cnt == CW'(NK - 1);
`ifdef AES_KEY_REUSE_EN
    logic r_new_key, w_new_key;
    // in_new_key is only meaningful with word 0, so later words use the captured copy
    assign w_new_key  = (r_cnt == '0) ? in_new_key : r_new_key;
    assign w_skip_key = r_key_loaded & ~w_new_key;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_new_key <= 1'b0;
        else if (w_acc && r_state == ST_LOAD_PT && r_cnt == '0) r_new_key <= in_new_key;
    end
`else
    assign w_skip_key = 1'b0;
`endif
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        unique case (r_state)
            ST_LOAD_PT: if (w_acc) begin
                w_cnt_next = w_pt_last ? '0 : r_cnt + 1'b1;
                if (w_pt_last) w_next = w_skip_key ? ST_HOLD : ST_LOAD_KEY;
            end
            ST_LOAD_KEY: if (w_acc) begin
                w_cnt_next = w_key_last ? '0 : r_cnt + 1'b1;
                if (w_key_last) w_next = ST_HOLD;
            end
            ST_HOLD: if (out_ready) w_next = ST_LOAD_PT;
            default: w_next = ST_LOAD_PT;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_LOAD_PT;
            r_cnt        <= '0;
            r_up         <= 1'b0;
            r_inv        <= 1'b0;
            r_key_loaded <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_up    <= 1'b1;
            if (w_acc && r_state == ST_LOAD_PT && r_cnt == '0) r_inv <= in_inverse;
            if (w_acc && r_state == ST_LOAD_KEY && w_key_last) r_key_loaded <= 1'b1;
        end
    end
    msk_word_deserializer #(.N(NPT), .W(W), .IW(CW)) u_pt (
        .clk(clk), .rst(rst), .i_en(w_acc && r_state == ST_LOAD_PT),
        .i_idx(r_cnt), .i_word(in_data), .o_bank(sh_plaintext)
    );
    msk_word_deserializer #(.N(NK), .W(W), .IW(CW)) u_key (
        .clk(clk), .rst(rst), .i_en(w_acc && r_state == ST_LOAD_KEY),
        .i_idx(r_cnt), .i_word(in_data), .o_bank(sh_key)
    );
    assign inverse   = r_inv;
    assign out_valid = r_state == ST_HOLD;
    assign busy      = (r_state != ST_LOAD_PT) | (r_cnt != '0);
endmodule

// File: tb/tb_msk_aes_share_loader.sv
// tb_msk_aes_share_loader: randomized self-checking bench against a word-array model of the loader.
// Set AES_KEY_REUSE_EN to exercise key reuse.
module tb_msk_aes_share_loader;
    localparam int d   = 2;
    localparam int W   = 32;
    localparam int NPT = 128 * d / W;
    localparam int NK  = 256 * d / W;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [W-1:0] in_data = '0;
    logic in_valid = 1'b0, in_inverse = 1'b0, out_ready = 1'b0, in_new_key = 1'b0;
    logic in_ready, inverse, out_valid, busy;
    logic [128*d-1:0] sh_plaintext;
    logic [256*d-1:0] sh_key;
    int errs = 0, checks = 0;
    logic [W-1:0] exp_pt [NPT];
    logic [W-1:0] exp_key [NK];
    logic exp_inv = 1'b0;
    bit key_loaded_m = 1'b0;
    msk_aes_share_loader #(.d(d), .W(W)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .in_inverse(in_inverse),
`ifdef AES_KEY_REUSE_EN
        .in_new_key(in_new_key),
`endif
        .sh_plaintext(sh_plaintext), .sh_key(sh_key), .inverse(inverse),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );
    always #5 clk = ~clk;
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    function automatic logic [128*d-1:0] pt_bus();
        logic [128*d-1:0] b;
        for (int i = 0; i < NPT; i++) b[i*W +: W] = exp_pt[i];
        return b;
    endfunction
    function automatic logic [256*d-1:0] key_bus();
        logic [256*d-1:0] b;
        for (int i = 0; i < NK; i++) b[i*W +: W] = exp_key[i];
        return b;
    endfunction
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic model_reset();
        for (int i = 0; i < NPT; i++) exp_pt[i] = '0;
        for (int i = 0; i < NK; i++) exp_key[i] = '0;
        exp_inv = 1'b0;
        key_loaded_m = 1'b0;
    endtask
    // Streams one block; the model decides whether the key phase happens.
    task automatic load_block(input bit seq, input bit gaps, input bit inv, input bit nk);
        int n;
        logic [W-1:0] w;
        n = NPT + NK;
`ifdef AES_KEY_REUSE_EN
        if (!nk && key_loaded_m) n = NPT;
`endif
        for (int i = 0; i < n; i++) begin
            w = seq ? ((i < NPT) ? W'(i) : W'(32'h100 + i - NPT)) : W'($urandom);
            if (i < NPT) exp_pt[i] = w;
            else exp_key[i-NPT] = w;
            in_valid   = 1'b1;
            in_data    = w;
            in_inverse = (i == 0) ? inv : ~inv;
            in_new_key = (i == 0) ? nk : 1'($urandom);
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                errs++;
                $display("FAIL load_handshake word %0d: in_ready=%b out_valid=%b, required 1/0", i, in_ready, out_valid);
            end
            checks++;
            if (busy !== (i != 0)) begin
                errs++;
                $display("FAIL load_busy word %0d: busy=%b, required %b", i, busy, i != 0);
            end
            cyc();
            if (gaps && i != n - 1) begin
                in_valid = 1'b0;
                in_data  = W'($urandom);
                cyc();
                checks++;
                if (busy !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
                    errs++;
                    $display("FAIL gap_state word %0d: busy=%b out_valid=%b in_ready=%b, required 1/0/1", i, busy, out_valid, in_ready);
                end
            end
        end
        in_valid = 1'b0;
        exp_inv  = inv;
        if (n == NPT + NK) key_loaded_m = 1'b1;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
            errs++;
            $display("FAIL hold_entry: out_valid=%b in_ready=%b busy=%b, required 1/0/1", out_valid, in_ready, busy);
        end
        checks++;
        if (sh_plaintext !== pt_bus()) begin
            errs++;
            $display("FAIL plaintext_bus: got %h, required %h", sh_plaintext, pt_bus());
        end
        checks++;
        if (sh_key !== key_bus()) begin
            errs++;
            $display("FAIL key_bus: got %h, required %h", sh_key, key_bus());
        end
        checks++;
        if (inverse !== exp_inv) begin
            errs++;
            $display("FAIL inverse: got %b, required %b", inverse, exp_inv);
        end
    endtask
    task automatic handshake();
        out_ready = 1'b1;
        cyc();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errs++;
            $display("FAIL handshake: out_valid=%b in_ready=%b busy=%b, required 0/1/0", out_valid, in_ready, busy);
        end
        checks++;
        if (sh_plaintext !== pt_bus() || sh_key !== key_bus()) begin
            errs++;
            $display("FAIL post_handshake_buses: pt=%h key=%h, required pt=%h key=%h", sh_plaintext, sh_key, pt_bus(), key_bus());
        end
    endtask
    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        #3;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || inverse !== 1'b0) begin
            errs++;
            $display("FAIL reset_ctrl: out_valid=%b busy=%b in_ready=%b inverse=%b, required 0/0/0/0", out_valid, busy, in_ready, inverse);
        end
        checks++;
        if (sh_plaintext !== '0 || sh_key !== '0) begin
            errs++;
            $display("FAIL reset_buses: pt=%h key=%h, required zero", sh_plaintext, sh_key);
        end
        cyc();
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errs++;
            $display("FAIL ready_before_edge: in_ready=%b, required 0", in_ready);
        end
        cyc();
        checks++;
        if (in_ready !== 1'b1) begin
            errs++;
            $display("FAIL ready_after_edge: in_ready=%b, required 1", in_ready);
        end
    endtask
    task automatic test_basic();
        out_ready = 1'b1;
        load_block(1'b1, 1'b0, 1'b0, 1'b1);
        checks++;
        if (sh_plaintext[255:224] !== 32'h7 || sh_key[511:480] !== 32'h10F || sh_plaintext[31:0] !== 32'h0) begin
            errs++;
            $display("FAIL basic_slices: pt_hi=%h pt_lo=%h key_hi=%h, required 7/0/10f", sh_plaintext[255:224], sh_plaintext[31:0], sh_key[511:480]);
        end
        handshake();
    endtask
    task automatic test_hold();
        out_ready = 1'b0;
        load_block(1'b0, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            in_data  = W'($urandom);
            cyc();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || sh_plaintext !== pt_bus() || sh_key !== key_bus()) begin
                errs++;
                $display("FAIL hold_stable cycle %0d: out_valid=%b in_ready=%b pt=%h key=%h", c, out_valid, in_ready, sh_plaintext, sh_key);
            end
        end
        in_valid = 1'b0;
        handshake();
    endtask
    task automatic test_gaps();
        out_ready = 1'b0;
        load_block(1'b1, 1'b1, 1'b0, 1'b1);
        handshake();
    endtask
    task automatic test_inverse();
        out_ready = 1'b0;
        load_block(1'b0, 1'b0, 1'b1, 1'b1);
        handshake();
    endtask
    task automatic test_back_to_back();
        out_ready = 1'b0;
        load_block(1'b0, 1'b0, 1'($urandom), 1'b1);
        handshake();
        out_ready = 1'b0;
        load_block(1'b0, 1'b0, 1'($urandom), 1'b1);
        handshake();
    endtask
    task automatic test_mid_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = W'($urandom);
            cyc();
        end
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || sh_plaintext !== '0) begin
            errs++;
            $display("FAIL mid_reset: out_valid=%b busy=%b pt=%h, required 0/0/0", out_valid, busy, sh_plaintext);
        end
        cyc();
        rst = 1'b0;
        cyc();
        load_block(1'b1, 1'b0, 1'b0, 1'b1);
        handshake();
    endtask
`ifdef AES_KEY_REUSE_EN
    task automatic test_key_reuse();
        rst = 1'b1;
        model_reset();
        cyc();
        rst = 1'b0;
        cyc();
        out_ready = 1'b0;
        load_block(1'b0, 1'b0, 1'b0, 1'b0);
        handshake();
        load_block(1'b0, 1'b0, 1'b0, 1'b1);
        handshake();
        load_block(1'b0, 1'b0, 1'b1, 1'b0);
        handshake();
    endtask
`endif
    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_hold();
        test_gaps();
        test_inverse();
        test_back_to_back();
        test_mid_reset();
`ifdef AES_KEY_REUSE_EN
        test_key_reuse();
`endif
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
